xadc_drp_writer: RTL and testbench
==================================

Name: xadc_drp_writer

Overview:
- DRP write initiator for the photoresistor XADC instance: the write side of the DRP link whose read side is the continuous-conversion data path.
- After reset it streams a fixed configuration sequence into the XADC control registers: single-channel VAUX6 mode and ADCCLK divider.
- It then accepts run-time register writes from the host side over a valid/ready handshake.
- The `drp_busy` output lets the top level gate the EOC-driven read enable, so only one initiator owns the DRP port at a time.

Parameters:
- NUM_INIT, 3, number of entries in the boot configuration sequence.
- TIMEOUT_CYCLES, 255, cycles to wait for DRDY before aborting a transaction (8-bit counter).

Ports:
- CLK100MHZ  input  1  system clock; all logic on its rising edge.
- CPU_RESETN  input  1  asynchronous active-low reset.
- req_valid  input  1  host write request valid.
- req_ready  output  1  high only in IDLE with init complete.
- req_addr  input  7  DRP register address.
- req_data  input  16  value to write.
- done  output  1  one-cycle pulse when a host write finishes, including on error.
- init_done  output  1  high once the boot sequence has completed; stays high.
- err  output  1  sticky DRDY timeout flag; cleared only by reset.
- verify_err  output  1  sticky read-back mismatch flag (see Optional Feature).
- drp_busy  output  1  high while this block owns the DRP.
- daddr  output  7  DRP address, driven to XADC daddr_in.
- den  output  1  DRP enable, one-cycle pulse per access.
- dwe  output  1  DRP write enable; valid only with den.
- di  output  16  DRP write data.
- drdy  input  1  DRP ready from XADC.
- do_in  input  16  DRP read data from XADC.

Behaviour:
- Reset values: all outputs 0, state INIT_ISSUE, ROM index 0, timeout counter 0.
- Boot ROM contents, in order: 0x40 <= 16'h0016 (channel VAUX6, no averaging); 0x41 <= 16'h3000 (single-channel sequencer); 0x42 <= 16'h0400 (ADCCLK divide by 4).
- INIT_ISSUE:
  - Registers daddr/di from ROM[index] and pulses den=1, dwe=1 for exactly one cycle.
  - drp_busy=1; goes to WAIT_RDY.
- WAIT_RDY:
  - daddr/di hold their values; the timeout counter increments each cycle.
  - drdy=1: counter clears; if servicing init, index++; go to INIT_ISSUE if index<NUM_INIT, else set init_done and go to IDLE; if servicing a host write, pulse done next cycle and go to IDLE.
  - Counter reaches TIMEOUT_CYCLES with no drdy: set err, treat as completed (index still advances, done still pulses).
  - drdy and timeout in the same cycle: drdy wins and err is not set.
- IDLE:
  - drp_busy=0; req_ready=init_done.
  - req_valid && req_ready: capture req_addr/req_data; go to HOST_ISSUE, which behaves as INIT_ISSUE but uses the captured values.
  - req_ready drops the cycle after acceptance.
- Latency: accept at cycle N, den at N+1; if drdy arrives at N+1+k, done at N+2+k.
- drdy outside WAIT_RDY is ignored (it belongs to the read path).
- req_valid during init or busy is not accepted; the host must hold it.
- Reset asserted mid-transaction: den/dwe drop immediately and init restarts from index 0 when reset releases.
- drp_busy is combinational from state (not IDLE), so the top level can gate eoc->den with zero lag.

Optional Feature:
- Macro XADC_VERIFY_EN.
- Defined:
  - After each write's drdy, the block enters VERIFY_ISSUE: den=1, dwe=0, same daddr.
  - It then enters VERIFY_WAIT, with the same timeout rules.
  - On drdy, it compares do_in to the written di; on mismatch it sets verify_err (sticky).
  - done and index advance only after the verify completes; latency grows by the read round trip.
- Undefined: no read-back states; verify_err tied to 0.

Decomposition:
- Package xadc_drp_pkg:
  - DRP address constants: CFG0=0x40, CFG1=0x41, CFG2=0x42.
  - Boot values.
  - State encoding localparams: INIT_ISSUE, WAIT_RDY, IDLE, HOST_ISSUE, VERIFY_ISSUE, VERIFY_WAIT.
- Sub-module xadc_cfg_rom: combinational index -> {addr, data} lookup of the NUM_INIT entries.

Test Plan:
- Reset release with a DRP model answering drdy 3 cycles after den: exactly 3 den pulses with dwe=1, addresses 0x40/0x41/0x42, data 0016/3000/0400; init_done high after the third drdy; err=0.
- Host write 0x41<=16'h0000 after init: req_ready drops the next cycle, den one cycle after acceptance, done pulses one cycle after drdy, req_ready returns.
- Model never asserts drdy on the 2nd boot write: err sets 255 cycles after den, the 3rd boot write still issues, init_done still sets.
- drdy coincident with the timeout terminal count: err stays 0.
- Reset pulsed while WAIT_RDY for the 2nd boot write: den/dwe go to 0 asynchronously; on release the sequence restarts at address 0x40.
- With XADC_VERIFY_EN defined, the model returns 16'h0017 on read-back of 0x40: verify_err set, read den seen with dwe=0, sequence continues.

Source files
------------

// File: rtl/xadc_drp_pkg.sv
// xadc_drp_pkg: DRP addresses, boot values and state encoding for the XADC DRP writer
package xadc_drp_pkg;
    localparam logic [6:0]  CFG0  = 7'h40;
    localparam logic [6:0]  CFG1  = 7'h41;
    localparam logic [6:0]  CFG2  = 7'h42;
    localparam logic [15:0] BOOT0 = 16'h0016;
    localparam logic [15:0] BOOT1 = 16'h3000;
    localparam logic [15:0] BOOT2 = 16'h0400;
    typedef enum logic [2:0] {
        INIT_ISSUE,
        WAIT_RDY,
        IDLE,
        HOST_ISSUE,
        VERIFY_ISSUE,
        VERIFY_WAIT
    } state_t;
endpackage

// File: rtl/xadc_cfg_rom.sv
// xadc_cfg_rom: boot configuration lookup, index -> {DRP address, value}
module xadc_cfg_rom
    import xadc_drp_pkg::*;
#(
    parameter int IW = 2
) (
    input  logic [IW-1:0] idx,
    output logic [6:0]    addr,
    output logic [15:0]   data
);
    // channel select, sequencer mode, then clock divider
    always_comb begin
        addr = idx == IW'(0) ? CFG0 : idx == IW'(1) ? CFG1 : CFG2;
        data = idx == IW'(0) ? BOOT0 : idx == IW'(1) ? BOOT1 : BOOT2;
    end
endmodule

// File: rtl/xadc_drp_writer.sv
// xadc_drp_writer: DRP write initiator, boot config stream then host writes; XADC_VERIFY_EN adds read-back check
module xadc_drp_writer
    import xadc_drp_pkg::*;
#(
    parameter int NUM_INIT       = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_addr,
    input  logic [15:0] req_data,
    output logic        done,
    output logic        init_done,
    output logic        err,
    output logic        verify_err,
    output logic        drp_busy,
    output logic [6:0]  daddr,
    output logic        den,
    output logic        dwe,
    output logic [15:0] di,
    input  logic        drdy,
    input  logic [15:0] do_in
);
    localparam int IW = NUM_INIT > 1 ? $clog2(NUM_INIT) : 1;
`ifdef XADC_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    state_t        state;
    logic [IW-1:0] idx;
    logic [7:0]    cnt;
    logic [6:0]    rom_addr;
    logic [15:0]   rom_data;
    logic          tmo;
    logic          to_verify;
    logic          mism;
    xadc_cfg_rom #(.IW(IW)) u_rom (
        .idx  (idx),
        .addr (rom_addr),
        .data (rom_data)
    );
    // the increment that would land on TIMEOUT_CYCLES ends the wait
    assign tmo       = cnt == 8'(TIMEOUT_CYCLES - 1);
    // gated by reset so the read path owns the DRP while this block is held off
    assign drp_busy  = CPU_RESETN && state != IDLE;
    assign to_verify = VERIFY && drdy && state != VERIFY_WAIT;
    assign mism      = VERIFY && drdy && state == VERIFY_WAIT && do_in != di;
    // transaction sequencer: issue, wait for drdy or timeout, then advance boot index or finish host write
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state      <= INIT_ISSUE;
            idx        <= '0;
            cnt        <= '0;
            req_ready  <= 1'b0;
            done       <= 1'b0;
            init_done  <= 1'b0;
            err        <= 1'b0;
            verify_err <= 1'b0;
            daddr      <= '0;
            den        <= 1'b0;
            dwe        <= 1'b0;
            di         <= '0;
        end else begin
            done       <= 1'b0;
            verify_err <= verify_err | mism;
            case (state)
                INIT_ISSUE: begin
                    daddr <= rom_addr;
                    di    <= rom_data;
                    den   <= 1'b1;
                    dwe   <= 1'b1;
                    cnt   <= '0;
                    state <= WAIT_RDY;
                end
                VERIFY_ISSUE: begin
                    den   <= 1'b1;
                    dwe   <= 1'b0;
                    cnt   <= '0;
                    state <= VERIFY_WAIT;
                end
                IDLE: begin
                    if (req_valid && req_ready) begin
                        daddr     <= req_addr;
                        di        <= req_data;
                        den       <= 1'b1;
                        dwe       <= 1'b1;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        state     <= HOST_ISSUE;
                    end
                end
                WAIT_RDY, HOST_ISSUE, VERIFY_WAIT: begin
                    den <= 1'b0;
                    dwe <= 1'b0;
                    cnt <= cnt + 8'd1;
                    if (drdy || tmo) begin
                        cnt <= '0;
                        err <= err | !drdy;
                        if (to_verify) begin
                            state <= VERIFY_ISSUE;
                        end else if (init_done) begin
                            done      <= 1'b1;
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end else if (idx == IW'(NUM_INIT - 1)) begin
                            init_done <= 1'b1;
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= INIT_ISSUE;
                        end
                    end
                end
                default: state <= INIT_ISSUE;
            endcase
        end
    end
endmodule

// File: tb/tb_xadc_drp_writer.sv
// tb_xadc_drp_writer: DRP responder model with access scoreboard, host write vector table, timeout/reset/verify sequences
module tb_xadc_drp_writer;
    import xadc_drp_pkg::*;
    localparam int TMO = 255;
`ifdef XADC_VERIFY_EN
    localparam bit V = 1'b1;
`else
    localparam bit V = 1'b0;
`endif
    typedef struct {
        logic [6:0]  a;
        logic [15:0] d;
        logic        we;
    } acc_t;
    typedef struct {
        logic [6:0]  a;
        logic [15:0] d;
        int          lat;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, done, init_done, err, verify_err, drp_busy;
    logic [6:0]  req_addr, daddr;
    logic [15:0] req_data, di, do_in, rv;
    logic        den, dwe, drdy;
    logic        prev_den, corrupt;
    logic [15:0] mem [128];
    acc_t        sbq [$];
    acc_t        e;
    int          lat_tab [$];
    int          wcyc [$];
    logic [6:0]  seen [$];
    int          pend, def_lat, wcnt, cyc, n, pas, tot;
    vec_t        vt [4];
    xadc_drp_writer dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .done       (done),
        .init_done  (init_done),
        .err        (err),
        .verify_err (verify_err),
        .drp_busy   (drp_busy),
        .daddr      (daddr),
        .den        (den),
        .dwe        (dwe),
        .di         (di),
        .drdy       (drdy),
        .do_in      (do_in)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act === exp) pas++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask
    task automatic push_acc(input logic [6:0] a, input logic [15:0] d, input bit rb);
        sbq.push_back('{a, d, 1'b1});
        if (V && rb) sbq.push_back('{a, d, 1'b0});
    endtask
    task automatic push_boot(input bit t2);
        push_acc(CFG0, BOOT0, 1'b1);
        push_acc(CFG1, BOOT1, !t2);
        push_acc(CFG2, BOOT2, 1'b1);
    endtask
    task automatic hold_reset();
        repeat (3) @(negedge clk);
        sbq.delete();
        lat_tab.delete();
        wcyc.delete();
        seen.delete();
        wcnt    = 0;
        def_lat = 3;
        corrupt = 1'b0;
    endtask
    task automatic wait_init();
        n = 0;
        while (!init_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("init_done", init_done, 1);
    endtask
    // DRP responder: answers each den after a per-access latency (0 = never) and checks it against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            drdy     = 1'b0;
            pend     = 0;
            prev_den = 1'b0;
        end else begin
            drdy = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drdy  = 1'b1;
                    do_in = rv;
                end
            end
            if (den) begin
                chk("den_single_cycle", prev_den, 0);
                seen.push_back(daddr);
                if (sbq.size() == 0) chk("den_unexpected", daddr, 7'h7f + 1);
                else begin
                    e = sbq.pop_front();
                    chk("drp_addr", daddr, e.a);
                    chk("drp_we", dwe, e.we);
                    if (e.we) chk("drp_data", di, e.d);
                end
                if (dwe) begin
                    mem[daddr] = di;
                    wcnt++;
                    wcyc.push_back(cyc);
                    pend = lat_tab.size() > 0 ? lat_tab.pop_front() : def_lat;
                end else begin
                    rv   = (corrupt && daddr == CFG0) ? 16'h0017 : mem[daddr];
                    pend = def_lat;
                end
            end
            prev_den = den;
        end
    end
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
    initial begin
        vt[0] = '{7'h41, 16'h0000, 3};
        vt[1] = '{7'h42, 16'h0400, 1};
        vt[2] = '{7'h40, 16'hA5C3, 6};
        vt[3] = '{7'h7F, 16'hFFFF, 2};
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
        do_in = '0; rv = '0; drdy = 1'b0; pas = 0; tot = 0; cyc = 0;
        hold_reset();
        chk("rst_den", den, 0);
        chk("rst_dwe", dwe, 0);
        chk("rst_done", done, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_err", err, 0);
        chk("rst_verify_err", verify_err, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_drp_busy", drp_busy, 0);
        chk("rst_daddr_di", {daddr, di}, 0);
        // boot sequence with 3-cycle responder
        push_boot(1'b0);
        rst_n = 1'b1;
        wait_init();
        chk("boot_writes", wcnt, 3);
        chk("boot_err", err, 0);
        chk("boot_req_ready", req_ready, 1);
        chk("boot_busy", drp_busy, 0);
        chk("boot_sb_empty", sbq.size(), 0);
        // host write vectors
        for (int i = 0; i < 4; i++) begin
            def_lat = vt[i].lat;
            push_acc(vt[i].a, vt[i].d, 1'b1);
            chk("host_ready_before", req_ready, 1);
            req_valid = 1'b1;
            req_addr  = vt[i].a;
            req_data  = vt[i].d;
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk("host_ready_drop", req_ready, 0);
            chk("host_den_lat", den, 1);
            chk("host_busy", drp_busy, 1);
            n = 0;
            while (!done && n < 1000) begin
                @(posedge clk); #1;
                n++;
            end
            chk("host_done_lat", n, vt[i].lat + 1 + (V ? vt[i].lat + 2 : 0));
            @(posedge clk); #1;
            chk("host_done_pulse", done, 0);
            chk("host_ready_back", req_ready, 1);
            @(negedge clk);
        end
        chk("host_sb_empty", sbq.size(), 0);
        chk("host_err", err, 0);
        // second boot write never answered
        rst_n = 1'b0;
        hold_reset();
        push_boot(1'b1);
        lat_tab = '{3, 0, 3};
        rst_n = 1'b1;
        n = 0;
        while (!err && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_err", err, 1);
        chk("tmo_lat", wcyc.size() > 1 ? cyc - wcyc[1] : -1, TMO);
        wait_init();
        chk("tmo_writes", wcnt, 3);
        chk("tmo_err_sticky", err, 1);
        chk("tmo_sb_empty", sbq.size(), 0);
        // drdy on the terminal count wins
        rst_n = 1'b0;
        hold_reset();
        push_boot(1'b0);
        lat_tab = '{3, TMO - 1, 3};
        rst_n = 1'b1;
        wait_init();
        chk("coinc_err", err, 0);
        chk("coinc_sb_empty", sbq.size(), 0);
        // reset while waiting on the second boot write
        rst_n = 1'b0;
        hold_reset();
        push_boot(1'b0);
        lat_tab = '{3, 0};
        rst_n = 1'b1;
        n = 0;
        while (!(den && daddr == CFG1) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_reached", {den, dwe, daddr}, {2'b11, CFG1});
        #2 rst_n = 1'b0;
        #1;
        chk("mid_den_async", den, 0);
        chk("mid_dwe_async", dwe, 0);
        chk("mid_busy", drp_busy, 0);
        hold_reset();
        push_boot(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        chk("mid_restart_addr", seen.size() > 0 ? seen[0] : 7'h00, CFG0);
        chk("mid_writes", wcnt, 3);
        chk("mid_sb_empty", sbq.size(), 0);
        // corrupted read-back of 0x40
        rst_n = 1'b0;
        hold_reset();
        corrupt = 1'b1;
        push_boot(1'b0);
        rst_n = 1'b1;
        wait_init();
        chk("verify_err", verify_err, V);
        chk("verify_no_tmo", err, 0);
        chk("verify_dens", seen.size(), V ? 6 : 3);
        chk("verify_sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", pas, tot);
        $finish;
    end
endmodule
